// File: rtl/axi_lite_init_sequencer_if.sv
// AXI4-Lite channel bundle between the init sequencer (master) and a register block (slave).
// Latency: none, wires only.
// Backpressure: standard AXI4-Lite VALID/READY on each of the five channels.
// Ports (per channel): AW addr/prot/valid/ready, W data/strb/valid/ready, B resp/valid/ready,
//   AR addr/prot/valid/ready, R data/resp/valid/ready.
interface axi_lite_init_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_init_sequencer.sv
// AXI4-Lite master replaying an init table (write, optional read-back compare) on a start pulse.
// Latency: zero-wait slave -> done 1+5*N cycles after start (1+3*N without read-back).
// Backpressure: VALIDs held until READY; per-state timeout aborts with err_code 3.
// Ports: ACLK/ARESET (sync, active-high), start, init_data (N entries packed LSB-first),
//   busy/done/pass/err_index/err_code status, m_axi (AXI4-Lite master modport).
// Option: define AXI_INIT_READBACK_EN to enable read-back and data compare per entry.
module axi_lite_init_sequencer #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_ENTRIES    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h43C00000,
  parameter int                    ADDR_STRIDE    = 4,
  parameter int                    TIMEOUT_CYCLES = 1024,
  localparam int                   IW             = $clog2(NUM_ENTRIES) + 1
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] init_data,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [IW-1:0]                     err_index,
  output logic [1:0]                        err_code,
  axi_lite_init_sequencer_if.master         m_axi
);

  localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_ENTRIES - 1);
  localparam logic [1:0]     ERR_RESP = 2'd1;
  localparam logic [1:0]     ERR_TMO  = 2'd3;

`ifdef AXI_INIT_READBACK_EN
  localparam logic [1:0]     ERR_DATA = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP,
                            S_NEXT, S_DONE, S_FAIL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RESP, S_NEXT, S_DONE, S_FAIL} state_t;
`endif

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  done_q, done_d, pass_q, pass_d;
  logic [IW-1:0]         err_index_q, err_index_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  fail;
  logic [1:0]            fail_code;
  logic                  aw_hs, w_hs, tmo;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] entry_dat;

  // Address arithmetic deliberately wraps at ADDR_WIDTH.
  assign addr      = BASE_ADDR + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STRIDE);
  assign entry_dat = init_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  // AW and W are tracked separately so each VALID drops right after its own handshake.
  assign m_axi.awaddr  = addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign m_axi.wdata   = entry_dat;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign m_axi.bready  = (state_q == S_WR_RESP);

`ifdef AXI_INIT_READBACK_EN
  assign m_axi.araddr  = addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state_q == S_RD_REQ);
  assign m_axi.rready  = (state_q == S_RD_RESP);
`else
  assign m_axi.araddr  = '0;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b0;
  logic unused_rd_in;
  assign unused_rd_in = ^{m_axi.arready, m_axi.rdata, m_axi.rresp, m_axi.rvalid};
`endif

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid && m_axi.wready;
  // The counter holds the number of completed cycles in the current state.
  assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

  assign busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_index = err_index_q;
  assign err_code  = err_code_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + 1'b1;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;
    fail        = 1'b0;
    fail_code   = 2'd0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d     = S_WR_REQ;
          idx_d       = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_index_d = '0;
          err_code_d  = 2'd0;
        end
      end
      S_WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = S_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end
      end
      S_WR_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else begin
`ifdef AXI_INIT_READBACK_EN
            state_d = S_RD_REQ;
`else
            state_d = S_NEXT;
`endif
          end
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end
      end
`ifdef AXI_INIT_READBACK_EN
      S_RD_REQ: begin
        if (m_axi.arready) begin
          state_d = S_RD_RESP;
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end
      end
      S_RD_RESP: begin
        if (m_axi.rvalid) begin
          // EXOKAY is not expected from a plain register block, so only OKAY passes.
          if (m_axi.rresp != 2'b00) begin
            fail      = 1'b1;
            fail_code = ERR_RESP;
          end else if (m_axi.rdata != entry_dat) begin
            fail      = 1'b1;
            fail_code = ERR_DATA;
          end else begin
            state_d = S_NEXT;
          end
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end
      end
`endif
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WR_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      state_d     = S_FAIL;
      aw_done_d   = 1'b0;
      w_done_d    = 1'b0;
      done_d      = 1'b1;
      pass_d      = 1'b0;
      err_index_d = idx_q;
      err_code_d  = fail_code;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_index_q <= '0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_init_sequencer.sv
// Directed bench for axi_lite_init_sequencer with a small behavioural AXI4-Lite RAM slave.
// Latency: expectations are cycle counts from the start-sampling edge to done.
// Backpressure: slave READY stalls, forced error responses and a held-off AWREADY are knobs.
module tb_axi_lite_init_sequencer;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h43C00000;
`ifdef AXI_INIT_READBACK_EN
  localparam int K  = 5;
  localparam int RB = 1;
`else
  localparam int K  = 3;
  localparam int RB = 0;
`endif

  logic          ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          ARESET;
  logic          start;
  logic [N*32-1:0] init_data;
  logic          busy, done, pass;
  logic [2:0]    err_index;
  logic [1:0]    err_code;

  axi_lite_init_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi_lite_init_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_ENTRIES(N), .BASE_ADDR(BASE),
    .ADDR_STRIDE(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .init_data(init_data),
    .busy(busy), .done(done), .pass(pass), .err_index(err_index), .err_code(err_code),
    .m_axi(axi.master)
  );

  int errors = 0;
  int checks = 0;

  // Slave knobs
  logic aw_block = 1'b0;
  logic stall_en = 1'b0;
  int   bresp_err_idx = -1;
  int   flip_idx = -1;

  // Slave state
  logic [31:0] mem [8];
  logic [31:0] wlog[$];
  logic [31:0] arlog[$];
  int          aw_wait, aw_need, w_wait, w_need;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;

  assign axi.awready = !aw_block && (aw_wait >= aw_need);
  assign axi.wready  = (w_wait >= w_need);
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = 1'b1;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = 2'b00;

  always @(posedge ACLK) begin : slave
    logic        aw_hs, w_hs;
    logic [31:0] a, d;
    int          i, r;
    if (ARESET) begin
      aw_wait <= 0; w_wait <= 0; aw_need <= 0; w_need <= stall_en ? 3 : 0;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b0; bresp_q <= 2'b00;
      rvalid_q <= 1'b0; rdata_q <= 32'h0;
    end else begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      if (axi.awvalid && !axi.awready) aw_wait <= aw_wait + 1;
      if (axi.wvalid && !axi.wready) w_wait <= w_wait + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= axi.awaddr; aw_wait <= 0; end
      if (w_hs)  begin w_got  <= 1'b1; w_data_l  <= axi.wdata;  w_wait  <= 0; end
      if (axi.bvalid && axi.bready) bvalid_q <= 1'b0;
      if ((aw_hs || aw_got) && (w_hs || w_got)) begin
        a = aw_hs ? axi.awaddr : aw_addr_l;
        d = w_hs ? axi.wdata : w_data_l;
        i = int'((a - BASE) >> 2) & 7;
        mem[i] = d;
        wlog.push_back(a);
        bvalid_q <= 1'b1;
        bresp_q  <= (i == bresp_err_idx) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (stall_en) begin
          r = $urandom_range(0, 2);
          aw_need <= r;
          w_need  <= r + 3;
        end
      end
      if (axi.rvalid && axi.rready) rvalid_q <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        i = int'((axi.araddr - BASE) >> 2) & 7;
        arlog.push_back(axi.araddr);
        rvalid_q <= 1'b1;
        rdata_q  <= mem[i] ^ ((i == flip_idx) ? 32'h1 : 32'h0);
      end
    end
  end

  // Protocol monitor: a pending VALID must stay up with stable payload; fixed attributes.
  logic        pv_aw = 1'b0, pv_w = 1'b0;
  logic [31:0] p_awaddr, p_wdata;
  int          stab_err = 0, attr_err = 0;
  always @(negedge ACLK) begin
    if (ARESET) begin
      pv_aw <= 1'b0;
      pv_w  <= 1'b0;
    end else begin
      if (pv_aw && (!axi.awvalid || axi.awaddr != p_awaddr)) stab_err++;
      if (pv_w && (!axi.wvalid || axi.wdata != p_wdata)) stab_err++;
      if (axi.awvalid && (axi.awprot != 3'b000 || axi.wstrb != 4'hF)) attr_err++;
      pv_aw    <= axi.awvalid && !axi.awready;
      pv_w     <= axi.wvalid && !axi.wready;
      p_awaddr <= axi.awaddr;
      p_wdata  <= axi.wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wcount(input logic [31:0] a);
    int c = 0;
    foreach (wlog[j]) if (wlog[j] == a) c++;
    return c;
  endfunction

  function automatic int arcount(input logic [31:0] a);
    int c = 0;
    foreach (arlog[j]) if (arlog[j] == a) c++;
    return c;
  endfunction

  function automatic logic [31:0] wat(input int k);
    return (wlog.size() > k) ? wlog[k] : 32'hxxxxxxxx;
  endfunction

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    start  = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    wlog.delete();
    arlog.delete();
  endtask

  // Pulse start, then count edges until done; optional second start pulse mid-run.
  task automatic run_seq(input int extra_at, output int edges);
    @(negedge ACLK);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    edges = 0;
    while (!done && edges < 500) begin
      start = (edges == extra_at);
      @(posedge ACLK); #1;
      edges++;
    end
    start = 1'b0;
    check("run_bounded", edges < 500, 1);
  endtask

  initial begin
    int lat, n;
    ARESET = 1'b1;
    start  = 1'b0;
    init_data = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_index", err_index, 0);
    check("rst_err_code", err_code, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_bready", axi.bready, 0);
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_rready", axi.rready, 0);

    // 1: zero-wait slave, full pass
    run_seq(-1, lat);
    check("t1_latency", lat, K * N);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err_code", err_code, 0);
    check("t1_busy", busy, 0);
    check("t1_nwrites", wlog.size(), 4);
    check("t1_waddr0", wat(0), 32'h43C00000);
    check("t1_waddr3", wat(3), 32'h43C0000C);
    check("t1_mem0", mem[0], 32'h0101FFFF);
    check("t1_mem1", mem[1], 32'habcd0001);
    check("t1_mem2", mem[2], 32'hdead0011);
    check("t1_mem3", mem[3], 32'hbeef0011);
    check("t1_nreads", arlog.size(), RB * 4);
    check("t1_attr", attr_err, 0);

    // 2: read data corrupted on entry 2
    do_reset();
    flip_idx = 2;
    run_seq(-1, lat);
    flip_idx = -1;
    check("t2_pass", pass, RB ? 0 : 1);
    check("t2_err_code", err_code, RB ? 2 : 0);
    check("t2_err_index", err_index, RB ? 2 : 0);
    check("t2_no_last_write", wcount(32'h43C0000C), RB ? 0 : 1);

    // 3: SLVERR on entry 1 write
    do_reset();
    bresp_err_idx = 1;
    run_seq(-1, lat);
    bresp_err_idx = -1;
    check("t3_done", done, 1);
    check("t3_pass", pass, 0);
    check("t3_err_code", err_code, 1);
    check("t3_err_index", err_index, 1);
    check("t3_no_ar_entry1", arcount(32'h43C00004), 0);
    check("t3_nreads", arlog.size(), RB);

    // 4: AWREADY ahead of WREADY by 3 cycles plus random stalls; start while busy ignored
    stall_en = 1'b1;
    do_reset();
    run_seq(4, lat);
    stall_en = 1'b0;
    check("t4_pass", pass, 1);
    check("t4_nwrites", wlog.size(), 4);
    check("t4_stalled", lat >= K * N + 12, 1);
    check("t4_valid_stable", stab_err, 0);
    check("t4_mem1", mem[1], 32'habcd0001);

    // 5: AWREADY never comes -> timeout
    aw_block = 1'b1;
    do_reset();
    run_seq(-1, lat);
    check("t5_latency", lat, 16);
    check("t5_pass", pass, 0);
    check("t5_err_code", err_code, 3);
    check("t5_err_index", err_index, 0);
    check("t5_awvalid_drop", axi.awvalid, 0);
    check("t5_wvalid_drop", axi.wvalid, 0);
    check("t5_busy", busy, 0);
    aw_block = 1'b0;

    // 6: reset during entry 1 write response, then clean rerun
    do_reset();
    @(negedge ACLK);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    n = 0;
    while (!(axi.bready && wlog.size() == 2) && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("t6_reach_wresp", n < 200, 1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_err_code", err_code, 0);
    check("t6_awvalid", axi.awvalid, 0);
    check("t6_bready", axi.bready, 0);
    wlog.delete();
    arlog.delete();
    run_seq(-1, lat);
    check("t6_pass", pass, 1);
    check("t6_first_addr", wat(0), 32'h43C00000);
    check("t6_nwrites", wlog.size(), 4);
    check("t6_latency", lat, K * N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
